// File: rtl/assoc_cache_wb_pkg.sv
// Shared definitions for the associative write-back cache.
// Contents: default widths, FSM state encoding, constant clog2 helper.
package cache_pkg;

    localparam int D_WIDTH_DEF = 8;
    localparam int A_WIDTH_DEF = 8;
    localparam int N_DEF       = 4;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOOKUP = 3'd1,
        S_WB     = 3'd2,
        S_FILL   = 3'd3,
        S_RESP   = 3'd4,
        S_FLUSH  = 3'd5
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/assoc_cache_wb_if.sv
// Memory-side bus of the cache.
// Ports: mem_req/mem_rw/mem_addr/mem_wdata driven by the cache (master),
// mem_rdata/mem_ack driven by the backing RAM (slave).
//
// Handshake: the master raises mem_req with mem_rw/mem_addr/mem_wdata and
// holds all of them stable until it samples mem_ack=1 on a rising edge.
// mem_ack is a one-cycle pulse; mem_rdata is valid only in that cycle.
// The master drops mem_req in the cycle after the ack. mem_ack while
// mem_req is low carries no meaning and is ignored.
interface assoc_cache_wb_if #(
    parameter int A_WIDTH = 8,
    parameter int D_WIDTH = 8
);
    logic               mem_req;
    logic               mem_rw;
    logic [A_WIDTH-1:0] mem_addr;
    logic [D_WIDTH-1:0] mem_wdata;
    logic [D_WIDTH-1:0] mem_rdata;
    logic               mem_ack;

    modport master (
        output mem_req, mem_rw, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_rw, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/assoc_cache_wb_lru.sv
// True-LRU bookkeeping plus valid bits for a fully associative cache.
// Ports: clk/clr, touch_en/touch_idx (mark entry most recently used),
// set_valid_en/set_valid_idx (mark entry valid), valid (per-entry valid
// vector), victim (lowest invalid entry, else the entry whose age is 0).
module cache_lru #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             touch_en,
    input  logic [IDX_W-1:0] touch_idx,
    input  logic             set_valid_en,
    input  logic [IDX_W-1:0] set_valid_idx,
    output logic [N-1:0]     valid,
    output logic [IDX_W-1:0] victim
);

    logic [IDX_W-1:0] age [N];

    // Ages stay a permutation of 0..N-1: the touched entry jumps to N-1 and
    // everything that was younger than it slides down by one.
    always_ff @(posedge clk) begin
        if (clr) begin
            valid <= '0;
            for (int i = 0; i < N; i++) age[i] <= IDX_W'(i);
        end else begin
            if (set_valid_en) valid[set_valid_idx] <= 1'b1;
            if (touch_en) begin
                for (int i = 0; i < N; i++) begin
                    if (IDX_W'(i) == touch_idx)
                        age[i] <= IDX_W'(N - 1);
                    else if (age[i] > age[touch_idx])
                        age[i] <= age[i] - 1'b1;
                end
            end
        end
    end

    always_comb begin
        logic found;
        victim = '0;
        found  = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!valid[i] && !found) begin
                victim = IDX_W'(i);
                found  = 1'b1;
            end
        end
        if (!found) begin
            for (int i = 0; i < N; i++) begin
                if (age[i] == '0) victim = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/assoc_cache_wb.sv
// Fully associative write-back, write-allocate cache with true LRU.
// Ports: clk, clr (sync clear); CPU side req/rw/addr/wdata/flush in,
// rdata/done/hit/busy/lru_idx out; memory side via assoc_cache_wb_if.master;
// state_dbg exposes the FSM state.
module assoc_cache_wb
    import cache_pkg::*;
#(
    parameter int D_WIDTH = D_WIDTH_DEF,
    parameter int A_WIDTH = A_WIDTH_DEF,
    parameter int N       = N_DEF,
    localparam int IDX_W  = clog2(N)
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               req,
    input  logic               rw,
    input  logic [A_WIDTH-1:0] addr,
    input  logic [D_WIDTH-1:0] wdata,
    input  logic               flush,
    output logic [D_WIDTH-1:0] rdata,
    output logic               done,
    output logic               hit,
    output logic               busy,
    output logic [IDX_W-1:0]   lru_idx,
    assoc_cache_wb_if.master   mem,
    output state_t             state_dbg
);

    state_t state, state_next;

    logic [A_WIDTH-1:0] tag  [N];
    logic [D_WIDTH-1:0] data [N];
    logic [N-1:0]       dirty;
    logic [N-1:0]       valid;

    logic               lat_rw;
    logic [A_WIDTH-1:0] lat_addr;
    logic [D_WIDTH-1:0] lat_wdata;
    logic [IDX_W-1:0]   vic, victim, vic_sel, fi, hit_idx, touch_idx;
    logic [D_WIDTH-1:0] rdata_r;
    logic               hit_r, hit_any, touch_en, install, fl_wr, fl_adv;

    cache_lru #(.N(N), .IDX_W(IDX_W)) u_lru (
        .clk          (clk),
        .clr          (clr),
        .touch_en     (touch_en),
        .touch_idx    (touch_idx),
        .set_valid_en (install),
        .set_valid_idx(vic_sel),
        .valid        (valid),
        .victim       (victim)
    );

    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (valid[i] && tag[i] == lat_addr && !hit_any) begin
                hit_any = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next    = state;
        touch_en      = 1'b0;
        touch_idx     = '0;
        install       = 1'b0;
        fl_adv        = 1'b0;
        mem.mem_req   = 1'b0;
        mem.mem_rw    = 1'b0;
        mem.mem_addr  = '0;
        mem.mem_wdata = '0;
        // The victim is only latched at the end of LOOKUP, so an install
        // decided in LOOKUP itself must use the live LRU output.
        vic_sel = (state == S_LOOKUP) ? victim : vic;
        fl_wr   = valid[fi] & dirty[fi];
        case (state)
            S_IDLE: begin
                if (flush)    state_next = S_FLUSH;
                else if (req) state_next = S_LOOKUP;
            end
            S_LOOKUP: begin
                if (hit_any) begin
                    touch_en   = 1'b1;
                    touch_idx  = hit_idx;
                    state_next = S_RESP;
                end else if (dirty[victim]) begin
                    state_next = S_WB;
                end else if (!lat_rw) begin
                    state_next = S_FILL;
                end else begin
                    install    = 1'b1;
                    state_next = S_RESP;
                end
            end
            S_WB: begin
                mem.mem_req   = 1'b1;
                mem.mem_rw    = 1'b1;
                mem.mem_addr  = tag[vic];
                mem.mem_wdata = data[vic];
                if (mem.mem_ack) begin
                    if (lat_rw) begin
                        install    = 1'b1;
                        state_next = S_RESP;
                    end else begin
                        state_next = S_FILL;
                    end
                end
            end
            S_FILL: begin
                mem.mem_req  = 1'b1;
                mem.mem_addr = lat_addr;
                if (mem.mem_ack) begin
                    install    = 1'b1;
                    state_next = S_RESP;
                end
            end
            S_FLUSH: begin
                if (fl_wr) begin
                    mem.mem_req   = 1'b1;
                    mem.mem_rw    = 1'b1;
                    mem.mem_addr  = tag[fi];
                    mem.mem_wdata = data[fi];
                end
                fl_adv = !fl_wr || mem.mem_ack;
                if (fl_adv && fi == IDX_W'(N - 1)) state_next = S_RESP;
            end
            S_RESP:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        if (install) begin
            touch_en  = 1'b1;
            touch_idx = vic_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            dirty     <= '0;
            lat_rw    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            vic       <= '0;
            fi        <= '0;
            rdata_r   <= '0;
            hit_r     <= 1'b0;
            for (int i = 0; i < N; i++) begin
                tag[i]  <= '0;
                data[i] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (flush) begin
                        fi    <= '0;
                        hit_r <= 1'b0;
                    end else if (req) begin
                        lat_rw    <= rw;
                        lat_addr  <= addr;
                        lat_wdata <= wdata;
                    end
                end
                S_LOOKUP: begin
                    vic   <= victim;
                    hit_r <= hit_any;
                    if (hit_any) begin
                        if (lat_rw) begin
                            data[hit_idx]  <= lat_wdata;
                            dirty[hit_idx] <= 1'b1;
                        end else begin
                            rdata_r <= data[hit_idx];
                        end
                    end
                end
                S_WB: if (mem.mem_ack) dirty[vic] <= 1'b0;
                S_FILL: begin
                    if (mem.mem_ack) begin
                        data[vic] <= mem.mem_rdata;
                        rdata_r   <= mem.mem_rdata;
                    end
                end
                S_FLUSH: begin
                    if (fl_wr && mem.mem_ack) dirty[fi] <= 1'b0;
                    if (fl_adv) fi <= fi + 1'b1;
                end
                default: ;
            endcase
            // Placed after the case so a write-allocate re-dirties the line
            // that the write-back in the same edge just cleaned.
            if (install) begin
                tag[vic_sel] <= lat_addr;
                if (lat_rw) begin
                    data[vic_sel]  <= lat_wdata;
                    dirty[vic_sel] <= 1'b1;
                end else begin
                    dirty[vic_sel] <= 1'b0;
                end
            end
        end
    end

    assign rdata     = rdata_r;
    assign hit       = hit_r;
    assign done      = (state == S_RESP);
    assign busy      = (state != S_IDLE);
    assign lru_idx   = victim;
    assign state_dbg = state;

endmodule

// File: tb/tb_assoc_cache_wb.sv
module tb_assoc_cache_wb;
  import cache_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       clr = 1'b1;
  logic       req = 1'b0, rw = 1'b0, flush = 1'b0;
  logic [7:0] addr = '0, wdata = '0;
  logic [7:0] rdata;
  logic       done, hit, busy;
  logic [1:0] lru_idx;
  state_t     st;

  assoc_cache_wb_if #(.A_WIDTH(8), .D_WIDTH(8)) mbus ();

  assoc_cache_wb #(.D_WIDTH(8), .A_WIDTH(8), .N(4)) dut (
    .clk(clk), .clr(clr), .req(req), .rw(rw), .addr(addr), .wdata(wdata),
    .flush(flush), .rdata(rdata), .done(done), .hit(hit), .busy(busy),
    .lru_idx(lru_idx), .mem(mbus), .state_dbg(st)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- memory model ----------------
  logic [7:0]  ram [256];
  logic        model_ack = 1'b0, spur_ack = 1'b0;
  logic [7:0]  model_rdata = '0;
  int          ack_delay = 0, cnt = 0;
  int          wr_cnt = 0, rd_cnt = 0, req_cycles = 0, stab_err = 0;
  logic [7:0]  last_rd_addr = '0, hold_addr = '0, hold_wdata = '0;
  logic        hold_rw = 1'b0, req_after_ack = 1'b0;
  logic [15:0] wr_q [$];
  logic [15:0] exp_q [$];

  assign mbus.mem_ack   = model_ack | spur_ack;
  assign mbus.mem_rdata = model_rdata;

  always @(negedge clk) begin
    if (mbus.mem_req) req_cycles++;
    if (model_ack) begin
      model_ack     = 1'b0;
      cnt           = 0;
      req_after_ack = mbus.mem_req;
    end else if (mbus.mem_req) begin
      if (cnt == 0) begin
        hold_addr  = mbus.mem_addr;
        hold_wdata = mbus.mem_wdata;
        hold_rw    = mbus.mem_rw;
      end else if (mbus.mem_addr !== hold_addr || mbus.mem_rw !== hold_rw ||
                   (hold_rw && mbus.mem_wdata !== hold_wdata)) begin
        stab_err++;
      end
      if (cnt == ack_delay) begin
        if (mbus.mem_rw) begin
          ram[mbus.mem_addr] = mbus.mem_wdata;
          wr_q.push_back({mbus.mem_addr, mbus.mem_wdata});
          wr_cnt++;
        end else begin
          model_rdata  = ram[mbus.mem_addr];
          last_rd_addr = mbus.mem_addr;
          rd_cnt++;
        end
        model_ack = 1'b1;
      end else begin
        cnt++;
      end
    end else begin
      cnt = 0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_clr();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    wr_q.delete();
  endtask

  task automatic access(input logic w, input logic [7:0] a, input logic [7:0] d,
                        output logic [7:0] rd, output logic h, output int cyc);
    @(negedge clk);
    req = 1'b1; rw = w; addr = a; wdata = d;
    cyc = 0;
    do begin
      @(negedge clk);
      req = 1'b0;
      cyc++;
    end while (!done && cyc < 200);
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL access_timeout addr=%h got done=%b exp 1", a, done);
    end
    rd = rdata;
    h  = hit;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    clr = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", done); end
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL rst_hit got %b exp 0", hit); end
    checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL rst_rdata got %h exp 00", rdata); end
    checks++; if (mbus.mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req got %b exp 0", mbus.mem_req); end
    checks++; if (lru_idx !== 2'd0) begin errors++; $display("FAIL rst_lru got %0d exp 0", lru_idx); end
    clr = 1'b0;
  endtask

  task automatic test_fill_and_hit();
    logic [7:0] rd; logic h; int cyc, r0, w0, q0;
    do_clr();
    ram[8'h10] = 8'h5A;
    r0 = rd_cnt; w0 = wr_cnt;
    access(1'b0, 8'h10, 8'h00, rd, h, cyc);
    checks++; if (h !== 1'b0) begin errors++; $display("FAIL t1_miss_hit got %b exp 0", h); end
    checks++; if (rd !== 8'h5A) begin errors++; $display("FAIL t1_miss_rdata got %h exp 5a", rd); end
    checks++; if (rd_cnt - r0 !== 1) begin errors++; $display("FAIL t1_fill_count got %0d exp 1", rd_cnt - r0); end
    checks++; if (last_rd_addr !== 8'h10) begin errors++; $display("FAIL t1_fill_addr got %h exp 10", last_rd_addr); end
    checks++; if (wr_cnt !== w0) begin errors++; $display("FAIL t1_no_wb got %0d exp %0d", wr_cnt, w0); end
    q0 = req_cycles;
    access(1'b0, 8'h10, 8'h00, rd, h, cyc);
    checks++; if (cyc !== 2) begin errors++; $display("FAIL t1_hit_latency got %0d exp 2", cyc); end
    checks++; if (h !== 1'b1) begin errors++; $display("FAIL t1_hit got %b exp 1", h); end
    checks++; if (rd !== 8'h5A) begin errors++; $display("FAIL t1_hit_rdata got %h exp 5a", rd); end
    checks++; if (req_cycles !== q0) begin errors++; $display("FAIL t1_hit_memreq got %0d exp %0d", req_cycles, q0); end
  endtask

  task automatic test_write_alloc_wb();
    logic [7:0] rd; logic h; int cyc, r0, w0, q0;
    do_clr();
    ram[8'h24] = 8'h99;
    r0 = rd_cnt; w0 = wr_cnt; q0 = req_cycles;
    for (int i = 0; i < 4; i++) begin
      access(1'b1, 8'h20 + 8'(i), 8'((i + 1) * 17), rd, h, cyc);
      checks++; if (h !== 1'b0) begin errors++; $display("FAIL t2_wmiss_hit i=%0d got %b exp 0", i, h); end
    end
    checks++; if (req_cycles !== q0 || wr_cnt !== w0 || rd_cnt !== r0) begin
      errors++; $display("FAIL t2_wmiss_traffic got %0d req cycles exp 0", req_cycles - q0);
    end
    checks++; if (lru_idx !== 2'd0) begin errors++; $display("FAIL t2_lru_before got %0d exp 0", lru_idx); end
    wr_q.delete();
    exp_q = '{16'h2011};
    access(1'b0, 8'h24, 8'h00, rd, h, cyc);
    checks++; if (h !== 1'b0) begin errors++; $display("FAIL t2_rmiss_hit got %b exp 0", h); end
    checks++; if (rd !== 8'h99) begin errors++; $display("FAIL t2_rmiss_rdata got %h exp 99", rd); end
    checks++; if (last_rd_addr !== 8'h24) begin errors++; $display("FAIL t2_fill_addr got %h exp 24", last_rd_addr); end
    checks++; if (wr_q.size() !== exp_q.size()) begin errors++; $display("FAIL t2_wb_count got %0d exp %0d", wr_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
      checks++; if (wr_q[i] !== exp_q[i]) begin errors++; $display("FAIL t2_wb_addr_data got %h exp %h", wr_q[i], exp_q[i]); end
    end
    checks++; if (lru_idx !== 2'd1) begin errors++; $display("FAIL t2_lru_after got %0d exp 1", lru_idx); end
  endtask

  task automatic test_lru_order();
    logic [7:0] rd; logic h; int cyc, r0;
    access(1'b0, 8'h21, 8'h00, rd, h, cyc);
    checks++; if (h !== 1'b1) begin errors++; $display("FAIL t3_hit got %b exp 1", h); end
    checks++; if (rd !== 8'h22) begin errors++; $display("FAIL t3_hit_rdata got %h exp 22", rd); end
    wr_q.delete();
    exp_q = '{16'h2233};
    r0 = rd_cnt;
    access(1'b1, 8'h30, 8'h77, rd, h, cyc);
    checks++; if (h !== 1'b0) begin errors++; $display("FAIL t3_wmiss_hit got %b exp 0", h); end
    checks++; if (wr_q.size() !== 1) begin errors++; $display("FAIL t3_wb_count got %0d exp 1", wr_q.size()); end
    else begin
      checks++; if (wr_q[0] !== exp_q[0]) begin errors++; $display("FAIL t3_victim got %h exp %h", wr_q[0], exp_q[0]); end
    end
    checks++; if (rd_cnt !== r0) begin errors++; $display("FAIL t3_no_fill got %0d exp %0d", rd_cnt, r0); end
    checks++; if (lru_idx !== 2'd3) begin errors++; $display("FAIL t3_lru got %0d exp 3", lru_idx); end
    access(1'b0, 8'h30, 8'h00, rd, h, cyc);
    checks++; if (h !== 1'b1 || rd !== 8'h77) begin errors++; $display("FAIL t3_readback got %b/%h exp 1/77", h, rd); end
  endtask

  task automatic test_flush();
    logic [7:0] rd; logic h, fh; int cyc, dn, r0, w0;
    do_clr();
    ram[8'h42] = 8'hB2;
    ram[8'h43] = 8'hB3;
    access(1'b1, 8'h40, 8'hA1, rd, h, cyc);
    access(1'b1, 8'h41, 8'hA2, rd, h, cyc);
    access(1'b0, 8'h42, 8'h00, rd, h, cyc);
    access(1'b0, 8'h43, 8'h00, rd, h, cyc);
    wr_q.delete();
    exp_q = '{16'h40A1, 16'h41A2};
    r0 = rd_cnt;
    @(negedge clk);
    flush = 1'b1; req = 1'b1; rw = 1'b0; addr = 8'h99;
    @(negedge clk);
    flush = 1'b0; req = 1'b0;
    dn = 0; fh = 1'b1;
    for (int c = 0; c < 60; c++) begin
      if (done) begin dn++; fh = hit; end
      @(negedge clk);
    end
    checks++; if (dn !== 1) begin errors++; $display("FAIL t4_done_count got %0d exp 1", dn); end
    checks++; if (fh !== 1'b0) begin errors++; $display("FAIL t4_flush_hit got %b exp 0", fh); end
    checks++; if (rd_cnt !== r0) begin errors++; $display("FAIL t4_req_ignored got %0d reads exp 0", rd_cnt - r0); end
    checks++; if (wr_q.size() !== exp_q.size()) begin errors++; $display("FAIL t4_wr_count got %0d exp %0d", wr_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
      checks++; if (wr_q[i] !== exp_q[i]) begin errors++; $display("FAIL t4_wr_addr_data got %h exp %h", wr_q[i], exp_q[i]); end
    end
    access(1'b0, 8'h40, 8'h00, rd, h, cyc);
    checks++; if (h !== 1'b1 || rd !== 8'hA1) begin errors++; $display("FAIL t4_still_valid got %b/%h exp 1/a1", h, rd); end
    w0 = wr_cnt;
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    dn = 0;
    for (int c = 0; c < 30; c++) begin
      if (done) dn++;
      @(negedge clk);
    end
    checks++; if (dn !== 1) begin errors++; $display("FAIL t4_reflush_done got %0d exp 1", dn); end
    checks++; if (wr_cnt !== w0) begin errors++; $display("FAIL t4_reflush_writes got %0d exp 0", wr_cnt - w0); end
  endtask

  task automatic test_slow_ack();
    logic [7:0] rd; logic h; int cyc, s0, q0, c;
    do_clr();
    ack_delay = 3;
    for (int i = 0; i < 4; i++) access(1'b1, 8'h50 + 8'(i), 8'hC0 + 8'(i), rd, h, cyc);
    wr_q.delete();
    exp_q = '{16'h50C0};
    s0 = stab_err; q0 = req_cycles;
    access(1'b1, 8'h54, 8'h55, rd, h, cyc);
    checks++; if (h !== 1'b0) begin errors++; $display("FAIL t5_hit got %b exp 0", h); end
    checks++; if (wr_q.size() !== 1) begin errors++; $display("FAIL t5_wb_count got %0d exp 1", wr_q.size()); end
    else begin
      checks++; if (wr_q[0] !== exp_q[0]) begin errors++; $display("FAIL t5_wb_addr_data got %h exp %h", wr_q[0], exp_q[0]); end
    end
    checks++; if (stab_err !== s0) begin errors++; $display("FAIL t5_stable got %0d changes exp 0", stab_err - s0); end
    checks++; if (req_cycles - q0 !== 4) begin errors++; $display("FAIL t5_req_len got %0d exp 4", req_cycles - q0); end
    checks++; if (req_after_ack !== 1'b0) begin errors++; $display("FAIL t5_req_drop got %b exp 0", req_after_ack); end
    // clear in the middle of a fill
    do_clr();
    access(1'b1, 8'h61, 8'hD1, rd, h, cyc);
    @(negedge clk);
    req = 1'b1; rw = 1'b0; addr = 8'h60;
    @(negedge clk);
    req = 1'b0;
    c = 0;
    while (!mbus.mem_req && c < 10) begin @(negedge clk); c++; end
    checks++; if (mbus.mem_req !== 1'b1) begin errors++; $display("FAIL t5_fill_started got %b exp 1", mbus.mem_req); end
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t5_clr_busy got %b exp 0", busy); end
    checks++; if (mbus.mem_req !== 1'b0) begin errors++; $display("FAIL t5_clr_mem_req got %b exp 0", mbus.mem_req); end
    checks++; if (done !== 1'b0 || lru_idx !== 2'd0) begin errors++; $display("FAIL t5_clr_outputs got %b/%0d exp 0/0", done, lru_idx); end
    ack_delay = 0;
    access(1'b0, 8'h61, 8'h00, rd, h, cyc);
    checks++; if (h !== 1'b0) begin errors++; $display("FAIL t5_invalidated got %b exp 0", h); end
    checks++; if (rd !== 8'hC4) begin errors++; $display("FAIL t5_refill_rdata got %h exp c4", rd); end
  endtask

  task automatic test_ignore();
    logic [7:0] rd, rd2; logic h; int cyc, dn, nb, r0, w0;
    do_clr();
    ack_delay = 0;
    r0 = rd_cnt;
    @(negedge clk);
    req = 1'b1; rw = 1'b0; addr = 8'h70;
    dn = 0; rd = '0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done) begin dn++; rd = rdata; end
      if (c == 0) begin rw = 1'b1; addr = 8'h71; wdata = 8'hEE; end
      if (c == 2) req = 1'b0;
    end
    checks++; if (dn !== 1) begin errors++; $display("FAIL t6_done_count got %0d exp 1", dn); end
    checks++; if (rd !== 8'hD5) begin errors++; $display("FAIL t6_rdata got %h exp d5", rd); end
    checks++; if (rd_cnt - r0 !== 1 || last_rd_addr !== 8'h70) begin errors++; $display("FAIL t6_single_fill got %0d/%h exp 1/70", rd_cnt - r0, last_rd_addr); end
    access(1'b0, 8'h71, 8'h00, rd2, h, cyc);
    checks++; if (h !== 1'b0 || rd2 !== 8'hD4) begin errors++; $display("FAIL t6_busy_write_dropped got %b/%h exp 0/d4", h, rd2); end
    r0 = rd_cnt; w0 = wr_cnt;
    @(negedge clk);
    spur_ack = 1'b1;
    @(negedge clk);
    spur_ack = 1'b0;
    dn = 0; nb = 0;
    for (int c = 0; c < 4; c++) begin
      if (done) dn++;
      if (busy) nb++;
      @(negedge clk);
    end
    checks++; if (dn !== 0 || nb !== 0) begin errors++; $display("FAIL t6_spurious_ack got done=%0d busy=%0d exp 0/0", dn, nb); end
    checks++; if (rd_cnt !== r0 || wr_cnt !== w0) begin errors++; $display("FAIL t6_spurious_traffic got %0d exp 0", (rd_cnt - r0) + (wr_cnt - w0)); end
    access(1'b0, 8'h70, 8'h00, rd, h, cyc);
    checks++; if (cyc !== 2 || h !== 1'b1 || rd !== 8'hD5) begin errors++; $display("FAIL t6_rehit got %0d/%b/%h exp 2/1/d5", cyc, h, rd); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 8'(i) ^ 8'hA5;
    test_reset();
    test_fill_and_hit();
    test_write_alloc_wb();
    test_lru_order();
    test_flush();
    test_slow_ack();
    test_ignore();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
